// File: rtl/fb_scanout_ctrl_pkg.sv
// Shared definitions for the frame-buffer scan-out controller.
// Contents: default raster geometry, scan FSM state type, the pixel struct
// and the pixel count of one frame.
package fb_scanout_ctrl_pkg;

  localparam int unsigned DEF_H_ACTIVE = 100;
  localparam int unsigned DEF_V_ACTIVE = 100;
  localparam int unsigned DEF_H_BLANK  = 4;
  localparam int unsigned DEF_V_BLANK  = 2;
  localparam int unsigned DEF_ADDR_W   = 20;
  localparam int unsigned FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank,
    StVblank
  } scan_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/fb_scanout_ctrl_if.sv
// Bus bundle of the scan-out controller.
// master: the controller (drives read enables, address, pixel stream, syncs,
//         swap_ack, front_sel; receives enable, swap_req and buffer read data).
// slave:  the surroundings (frame buffers, writer side, display sink).
interface fb_scanout_ctrl_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              enable;
  logic              swap_req;
  logic              swap_ack;
  logic              front_sel;
  logic              re0;
  logic              re1;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        r0, g0, b0;
  logic [7:0]        r1, g1, b1;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic              pix_valid;
  logic              hsync;
  logic              vsync;
  logic              frame_start;

  modport master (
    input  enable, swap_req, r0, g0, b0, r1, g1, b1,
    output swap_ack, front_sel, re0, re1, addr, pix_r, pix_g, pix_b, pix_valid,
           hsync, vsync, frame_start
  );

  modport slave (
    output enable, swap_req, r0, g0, b0, r1, g1, b1,
    input  swap_ack, front_sel, re0, re1, addr, pix_r, pix_g, pix_b, pix_valid,
           hsync, vsync, frame_start
  );
endinterface

// File: rtl/fb_scanout_ctrl_timing.sv
// Raster timing generator: scan FSM plus horizontal/vertical counters.
// Ports: clk, reset (sync, active-high), enable in;
//        re (front-buffer read strobe), addr (linear pixel address),
//        hblank, vblank, first_pix (pixel 0,0 being addressed) and
//        frame_end (last VBLANK cycle) out. All outputs decode registers.
module fb_scanout_ctrl_timing
  import fb_scanout_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_BLANK  = DEF_V_BLANK,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              re,
  output logic [ADDR_W-1:0] addr,
  output logic              hblank,
  output logic              vblank,
  output logic              first_pix,
  output logic              frame_end
);

  localparam int unsigned LINE = H_ACTIVE + H_BLANK;
  localparam int unsigned HW   = $clog2(LINE + 1);
  localparam int unsigned VW   = $clog2(V_ACTIVE + V_BLANK + 1);

  scan_state_e       state_q;
  logic [HW-1:0]     h_q;     // pixel / blank-cycle position in the line
  logic [VW-1:0]     v_q;     // active line, or blank line while in VBLANK
  logic [ADDR_W-1:0] addr_q;

  assign frame_end = (state_q == StVblank) && (h_q == HW'(LINE - 1)) &&
                     (v_q == VW'(V_BLANK - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StActive;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
          end
        end
        StActive: begin
          // addr holds on the last pixel of a line and resumes with the next line
          if (h_q == HW'(H_ACTIVE - 1)) begin
            state_q <= StHblank;
            h_q     <= '0;
          end else begin
            h_q    <= h_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        StHblank: begin
          if (h_q == HW'(H_BLANK - 1)) begin
            h_q <= '0;
            if (v_q == VW'(V_ACTIVE - 1)) begin
              state_q <= StVblank;
              v_q     <= '0;
            end else begin
              state_q <= StActive;
              v_q     <= v_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
            end
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        StVblank: begin
          if (frame_end) begin
            state_q <= enable ? StActive : StIdle;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
          end else if (h_q == HW'(LINE - 1)) begin
            h_q <= '0;
            v_q <= v_q + 1'b1;
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign re        = (state_q == StActive);
  assign addr      = addr_q;
  assign hblank    = (state_q == StHblank);
  assign vblank    = (state_q == StVblank);
  assign first_pix = re && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/fb_scanout_ctrl.sv
// Frame-buffer scan-out controller (top).
// Ports: clk, reset (sync, active-high) and bus (fb_scanout_ctrl_if.master):
//   enable/swap_req in, swap_ack/front_sel out, re0/re1/addr to the buffers,
//   r/g/b0 and r/g/b1 read data in (1-cycle buffer latency), pix_r/g/b,
//   pix_valid, hsync, vsync, frame_start out, all two cycles after the address.
// Front/back buffers swap only on the last VBLANK cycle.
module fb_scanout_ctrl
  import fb_scanout_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_BLANK  = DEF_V_BLANK,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input logic               clk,
  input logic               reset,
  fb_scanout_ctrl_if.master bus
);

  logic              re, hblank, vblank, first_pix, frame_end;
  logic [ADDR_W-1:0] addr;

  fb_scanout_ctrl_timing #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK),
    .ADDR_W   (ADDR_W)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .enable    (bus.enable),
    .re        (re),
    .addr      (addr),
    .hblank    (hblank),
    .vblank    (vblank),
    .first_pix (first_pix),
    .frame_end (frame_end)
  );

  // Swap control; armed_q drops after a swap until swap_req is seen low,
  // so a request held across several frames toggles only once.
  logic front_q, armed_q, ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q <= 1'b0;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (frame_end && bus.swap_req && armed_q) begin
        front_q <= ~front_q;
        ack_q   <= 1'b1;
        armed_q <= 1'b0;
      end else if (!bus.swap_req) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Stage 1 runs alongside the buffer register; s1_sel is the front_sel that
  // issued the read, so the mux never picks the other buffer after a swap.
  logic   s1_valid, s1_hs, s1_vs, s1_fs, s1_sel;
  logic   valid_q, hs_q, vs_q, fs_q;
  pixel_t pix_d, pix_q;

  always_comb begin
    pix_d = '0;
    if (s1_valid) begin
      pix_d = s1_sel ? {bus.r1, bus.g1, bus.b1} : {bus.r0, bus.g0, bus.b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_fs    <= 1'b0;
      s1_sel   <= 1'b0;
      valid_q  <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      fs_q     <= 1'b0;
      pix_q    <= '0;
    end else begin
      s1_valid <= re;
      s1_hs    <= hblank;
      s1_vs    <= vblank;
      s1_fs    <= first_pix;
      s1_sel   <= front_q;
      valid_q  <= s1_valid;
      hs_q     <= s1_hs;
      vs_q     <= s1_vs;
      fs_q     <= s1_fs;
      pix_q    <= pix_d;
    end
  end

  assign bus.re0         = re & ~front_q;
  assign bus.re1         = re & front_q;
  assign bus.addr        = addr;
  assign bus.swap_ack    = ack_q;
  assign bus.front_sel   = front_q;
  assign bus.pix_r       = pix_q.r;
  assign bus.pix_g       = pix_q.g;
  assign bus.pix_b       = pix_q.b;
  assign bus.pix_valid   = valid_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.frame_start = fs_q;

endmodule
